// File: rtl/cordic_iter_ctrl.sv
// Sequencing controller for the iterative CORDIC datapath: loads operands, samples the
// direction decision each iteration and issues rotate / normalise strobes with a result handshake.
module cordic_iter_ctrl #(
    parameter int ITER     = 8,
    parameter int CNT_W    = 4,
    parameter int NORM_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vmode,
    input  logic             abort,
    input  logic             dec_dn,
    input  logic             dec_d,
    output logic             ready,
    output logic             ld_en,
    output logic             dec_smp,
    output logic             rot_en,
    output logic             rot_dir,
    output logic             norm_en,
    output logic             mode,
    output logic [CNT_W-1:0] shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    localparam int NC_W = $clog2(NORM_MAX + 2);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(ITER - 1);
    localparam logic [NC_W-1:0]  NORM_LIM   = NC_W'(NORM_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DECIDE,
        STEP,
        DONE
    } state_t;

    state_t          state;
    logic [NC_W-1:0] norm_cnt;
    logic            dn_q;
    logic            d_q;

    // NOTE: every register below uses non-blocking assignments so all state updates
    // see the pre-edge values of each other, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_amt <= '0;
            mode      <= 1'b0;
            err       <= 1'b0;
            norm_cnt  <= '0;
            dn_q      <= 1'b0;
            d_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode      <= vmode;
                        shift_amt <= '0;
                        norm_cnt  <= '0;
                        err       <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: state <= abort ? IDLE : DECIDE;
                DECIDE: begin
                    dn_q  <= dec_dn;
                    d_q   <= dec_d;
                    state <= abort ? IDLE : STEP;
                end
                STEP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (dn_q) begin
                        norm_cnt <= norm_cnt + NC_W'(1);
                        if (norm_cnt + NC_W'(1) == NORM_LIM) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= DECIDE;
                        end
                    end else begin
                        norm_cnt <= '0;
                        if (shift_amt == LAST_SHIFT) begin
                            state <= DONE;
                        end else begin
                            shift_amt <= shift_amt + CNT_W'(1);
                            state     <= DECIDE;
                        end
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: strobes are decoded from state and gated by abort in the same cycle, so an
    // aborted step never reaches the datapath; decoding from state also makes reset immediate.
    assign ready     = (state == IDLE);
    assign ld_en     = (state == LOAD) && !abort;
    assign dec_smp   = (state == DECIDE);
    assign rot_en    = (state == STEP) && !abort && !dn_q;
    assign norm_en   = (state == STEP) && !abort && dn_q;
    assign rot_dir   = d_q;
    assign out_valid = (state == DONE);

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Sequencing controller for the iterative CORDIC datapath.
- Accepts a start request, loads operands and runs a fixed number of micro-rotations. Each iteration samples the datapath's combinational direction-decision outputs (d, dn) and issues rotate or normalise strobes.
- Presents a valid/ready result handshake to the requester.
- Sits between the requesting unit and the CORDIC datapath plus decision logic. It owns the iteration counter and shift amount.

Parameters:
- ITER, 8, number of rotation iterations per operation (2..15).
- CNT_W, 4, width of iteration counter and shift_amt; must satisfy 2^CNT_W > ITER.
- NORM_MAX, 3, maximum consecutive normalise steps allowed before err is raised.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; accepted only when ready=1.
- vmode  in  1  vectoring(1)/rotation(0) mode; latched on acceptance.
- abort  in  1  cancel the current operation.
- dec_dn  in  1  decision: 1 = no rotation this step, normalise instead.
- dec_d  in  1  decision: rotation direction (1 = add, 0 = subtract); valid when dec_dn=0.
- ready  out  1  idle and able to accept start.
- ld_en  out  1  one-cycle operand load strobe to the datapath.
- dec_smp  out  1  decision-sample cycle marker; dec_d and dec_dn are registered on this cycle.
- rot_en  out  1  one-cycle rotate strobe.
- rot_dir  out  1  registered dec_d, valid with rot_en.
- norm_en  out  1  one-cycle normalise strobe.
- mode  out  1  latched vmode.
- shift_amt  out  CNT_W  current iteration index.
- out_valid  out  1  result available.
- out_ready  in  1  requester accepts the result.
- err  out  1  normalise limit exceeded; sticky until next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, shift_amt=0, mode=0, err=0.
  - All strobes and out_valid are 0.
- States: IDLE, LOAD, DECIDE, STEP, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch mode<=vmode, clear shift_amt, clear norm counter, clear err; go to LOAD.
- LOAD: ld_en=1 for exactly one cycle; go to DECIDE.
- DECIDE:
  - dec_smp=1.
  - Register dec_dn and dec_d into internal flops; go to STEP.
- STEP, using the registered decision:
  - dn=1: norm_en=1; shift_amt unchanged; norm counter +1. If the counter reaches NORM_MAX+1, set err=1 and go to DONE; otherwise go to DECIDE.
  - dn=0: rot_en=1, rot_dir=registered d; norm counter cleared. If shift_amt==ITER-1, go to DONE; else shift_amt+1 and go to DECIDE.
- DONE:
  - out_valid=1, held until out_ready=1; then go to IDLE on the next edge.
  - shift_amt holds its final value until the next start.
- Latency: with no normalise steps, start sampled at cycle 0 gives out_valid at cycle 2+2*ITER. Each normalise step adds 2 cycles.
- Exactly one of ld_en, rot_en, norm_en is high in any cycle, or none.
- abort=1 in LOAD/DECIDE/STEP:
  - Go to IDLE on the next edge; no strobe is issued that cycle.
  - out_valid stays 0; err unchanged.
  - abort is ignored in IDLE and DONE.
- start while ready=0: ignored, with no side effects.
- start in the same cycle as the DONE handshake: ignored. ready rises one cycle later.
- Reset asserted mid-operation: immediate return to reset values; no partial strobes.
- shift_amt never exceeds ITER-1 and never wraps.

Test Plan:
- Basic rotation, ITER=8, dec_dn=0, dec_d alternating 1,0 -> rot_en pulses at cycles 3,5,...,17; rot_dir sequence 1,0,1,0...; shift_amt 0..7; out_valid at cycle 18.
- Normalise insertion: dec_dn=1 on the 2nd decision only -> one norm_en pulse with shift_amt=1 held; out_valid at cycle 20; err=0.
- Normalise limit, NORM_MAX=3, dec_dn stuck at 1 -> four norm_en pulses, err=1, then DONE with out_valid=1; err clears on the next accepted start.
- Back-pressure: out_ready=0 for 5 cycles after DONE -> out_valid held 6 cycles; start during the handshake cycle ignored; ready=1 the following cycle.
- abort asserted in the 3rd STEP -> no strobe that cycle; IDLE next cycle with ready=1; out_valid never rises; a new start runs the full sequence.
- Async reset pulse mid-DECIDE (between clock edges) -> all outputs reach reset values immediately; ready=1 after release.
